spi_slave_mc: RTL and testbench

Parametrised, multi-mode SPI slave for the FPGA fabric. It oversamples SCK, SSEL_n and MOSI on the system clock and supports all four CPOL/CPHA modes and a configurable word width. A one-entry transmit holding buffer with a valid/ready handshake lets the upper protocol state machine queue the next response word while the current one shifts out. It replaces the fixed 8-bit, mode-0, LED-demo slave as the serial front end for the command/response logic.

---
 rtl/spi_slave_mc_if.sv | 40 ++++
 rtl/spi_slave_mc.sv | 210 +++++++++++++++++++++
 tb/tb_spi_slave_mc.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_mc_if.sv
// spi_slave_mc_if
//   Bundles the SPI pins, mode inputs, receive stream, transmit holding-buffer
//   handshake and frame status of spi_slave_mc.
//   Modports:
//     slave  - the SPI slave block (drives miso, rx_*, tx_ready, status).
//     master - the surrounding logic / pad ring (drives pins, mode, tx_*).
//   Parameters: WIDTH (bits per word), CNT_W (word counter width).
interface spi_slave_mc_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             sck;
    logic             ssel_n;
    logic             mosi;
    logic             cpol;
    logic             cpha;
    logic             miso;
    logic             miso_oe;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_underrun;
    logic             frame_active;
    logic             frame_abort;
    logic [CNT_W-1:0] word_count;

    modport slave (
        input  sck, ssel_n, mosi, cpol, cpha, tx_data, tx_valid,
        output miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun,
               frame_active, frame_abort, word_count
    );

    modport master (
        output sck, ssel_n, mosi, cpol, cpha, tx_data, tx_valid,
        input  miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun,
               frame_active, frame_abort, word_count
    );
endinterface

// File: rtl/spi_slave_mc.sv
// spi_slave_mc
//   Oversampled multi-mode SPI slave. SCK, SSEL_n and MOSI are synchronised
//   into clk and edge-detected; all four CPOL/CPHA modes are supported with a
//   WIDTH-bit MSB-first word. A one-entry transmit holding buffer (valid/ready)
//   feeds the transmit shift register; DEFAULT_RESP is sent when it is empty.
//   Ports:
//     clk    - system clock, all logic on posedge
//     rst_n  - asynchronous active-low reset
//     bus    - spi_slave_mc_if.slave: pins, mode, rx stream, tx handshake,
//              frame status and per-frame word counter
module spi_slave_mc #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] DEFAULT_RESP = '0,
    parameter int               CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_slave_mc_if.slave bus
);
    localparam int               BIT_W    = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // {sck, ssel_n, mosi}
    logic [2:0]       sync1_reg;
    logic [2:0]       sync2_reg;
    logic             sck_d_reg;
    logic             ssel_d_reg;

    logic [0:0]       state_reg;
    logic             cpol_reg;
    logic             cpha_reg;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic [WIDTH-1:0] rx_shift_reg;
    logic [WIDTH-1:0] rx_data_reg;
    logic             rx_valid_reg;
    logic             word_done_reg;
    logic             load_pend_reg;
    logic [WIDTH-1:0] tx_shift_reg;
    logic [WIDTH-1:0] buf_reg;
    logic             buf_full_reg;
    logic             miso_reg;
    logic             underrun_reg;
    logic             abort_reg;
    logic [CNT_W-1:0] word_count_reg;

    logic             sck_s;
    logic             ssel_s;
    logic             mosi_s;
    logic             sck_rise;
    logic             sck_fall;
    logic             ssel_rise;
    logic             ssel_fall;
    logic             lead_edge;
    logic             trail_edge;
    logic             sample_edge;
    logic             launch_edge;
    logic             active;
    logic             frame_start;
    logic             in_frame;
    logic             accept;
    logic             load;
    logic             underrun;
    logic [WIDTH-1:0] load_word;

    // The ssel_n chain resets to 0 (selected) so that a select that is already
    // low when reset releases never produces a falling edge; only a fresh
    // high-to-low transition starts a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            sck_d_reg  <= 1'b0;
            ssel_d_reg <= 1'b0;
        end else begin
            sync1_reg  <= {bus.sck, bus.ssel_n, bus.mosi};
            sync2_reg  <= sync1_reg;
            sck_d_reg  <= sync2_reg[2];
            ssel_d_reg <= sync2_reg[1];
        end
    end

    assign sck_s  = sync2_reg[2];
    assign ssel_s = sync2_reg[1];
    assign mosi_s = sync2_reg[0];

    assign sck_rise  = sck_s & ~sck_d_reg;
    assign sck_fall  = ~sck_s & sck_d_reg;
    assign ssel_rise = ssel_s & ~ssel_d_reg;
    assign ssel_fall = ~ssel_s & ssel_d_reg;

    assign lead_edge   = cpol_reg ? sck_fall : sck_rise;
    assign trail_edge  = cpol_reg ? sck_rise : sck_fall;
    assign sample_edge = cpha_reg ? trail_edge : lead_edge;
    assign launch_edge = cpha_reg ? lead_edge : trail_edge;

    assign active      = (state_reg == ST_ACTIVE);
    assign frame_start = (state_reg == ST_IDLE) && ssel_fall;
    // A select release takes priority over any SCK edge seen in the same cycle.
    assign in_frame    = active && !ssel_rise;

    assign accept = bus.tx_valid && !buf_full_reg;

    // Mode 0/2 must present the first bit before the first (sampling) edge, so
    // that load happens on frame entry using the live cpha pin being latched.
    assign load = (frame_start && !bus.cpha)
               || (in_frame && launch_edge && load_pend_reg);

    // An accept that coincides with a load on an empty buffer bypasses it.
    assign load_word = buf_full_reg ? buf_reg
                     : (accept ? bus.tx_data : DEFAULT_RESP);
    assign underrun  = load && !buf_full_reg && !accept;

    // Frame control and receive path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cpol_reg      <= 1'b0;
            cpha_reg      <= 1'b0;
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            word_done_reg <= 1'b0;
            load_pend_reg <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            word_done_reg <= 1'b0;
            abort_reg     <= 1'b0;
            if (frame_start) begin
                state_reg     <= ST_ACTIVE;
                cpol_reg      <= bus.cpol;
                cpha_reg      <= bus.cpha;
                bit_cnt_reg   <= '0;
                load_pend_reg <= bus.cpha;
            end else if (active && ssel_rise) begin
                state_reg     <= ST_IDLE;
                bit_cnt_reg   <= '0;
                load_pend_reg <= 1'b0;
                abort_reg     <= (bit_cnt_reg != '0);
            end else if (in_frame) begin
                if (launch_edge && load_pend_reg) begin
                    load_pend_reg <= 1'b0;
                end
                if (sample_edge) begin
                    rx_shift_reg <= {rx_shift_reg[WIDTH-2:0], mosi_s};
                    if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_reg   <= '0;
                        word_done_reg <= 1'b1;
                        load_pend_reg <= 1'b1;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
        end
    end

    // Transmit path, holding buffer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            word_count_reg <= '0;
            tx_shift_reg   <= '0;
            buf_reg        <= '0;
            buf_full_reg   <= 1'b0;
            underrun_reg   <= 1'b0;
            miso_reg       <= 1'b0;
        end else begin
            rx_valid_reg <= word_done_reg;
            if (word_done_reg) begin
                rx_data_reg <= rx_shift_reg;
            end

            if (frame_start) begin
                word_count_reg <= '0;
            end else if (word_done_reg && (word_count_reg != '1)) begin
                word_count_reg <= word_count_reg + CNT_W'(1);
            end

            if (load) begin
                tx_shift_reg <= load_word;
            end else if (in_frame && launch_edge) begin
                tx_shift_reg <= tx_shift_reg << 1;
            end

            if (load) begin
                buf_full_reg <= 1'b0;
            end else if (accept) begin
                buf_full_reg <= 1'b1;
                buf_reg      <= bus.tx_data;
            end

            underrun_reg <= underrun;
            // Extra register stage puts miso 4 clk after the pin edge.
            miso_reg     <= active ? tx_shift_reg[WIDTH-1] : 1'b0;
        end
    end

    assign bus.miso         = miso_reg;
    assign bus.miso_oe      = active;
    assign bus.rx_data      = rx_data_reg;
    assign bus.rx_valid     = rx_valid_reg;
    assign bus.tx_ready     = !buf_full_reg;
    assign bus.tx_underrun  = underrun_reg;
    assign bus.frame_active = active;
    assign bus.frame_abort  = abort_reg;
    assign bus.word_count   = word_count_reg;
endmodule

// File: tb/tb_spi_slave_mc.sv
// tb_spi_slave_mc
//   Randomised and directed bench for spi_slave_mc with two instances:
//   an 8-bit one (CNT_W=16) and a 16-bit one (CNT_W=2, to reach saturation).
//   A behavioural SPI master drives the pins; a transaction-level model
//   predicts received words, miso words, underruns and aborts, and a monitor
//   pops the expectation queues whenever the DUT presents a result.
module tb_spi_slave_mc;
    localparam logic [7:0]  DEF8  = 8'hC3;
    localparam logic [15:0] DEF16 = 16'h0F0F;
    localparam int          HALF  = 8;   // clk cycles per SCK half period

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sck_drv  = 1'b0;
    logic ssel_drv = 1'b1;
    logic mosi_drv = 1'b0;
    logic cpol_drv = 1'b0;
    logic cpha_drv = 1'b0;
    logic use16    = 1'b0;

    spi_slave_mc_if #(.WIDTH(8),  .CNT_W(16)) if8 ();
    spi_slave_mc_if #(.WIDTH(16), .CNT_W(2))  if16 ();

    spi_slave_mc #(.WIDTH(8), .DEFAULT_RESP(DEF8), .CNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8));
    spi_slave_mc #(.WIDTH(16), .DEFAULT_RESP(DEF16), .CNT_W(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(if16));

    assign if8.sck     = sck_drv;
    assign if8.mosi    = mosi_drv;
    assign if8.cpol    = cpol_drv;
    assign if8.cpha    = cpha_drv;
    assign if8.ssel_n  = use16 ? 1'b1 : ssel_drv;
    assign if16.sck    = sck_drv;
    assign if16.mosi   = mosi_drv;
    assign if16.cpol   = cpol_drv;
    assign if16.cpha   = cpha_drv;
    assign if16.ssel_n = use16 ? ssel_drv : 1'b1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // DUT-side transmit feeders and model-side copies of the same words.
    logic [31:0] feed8[$], feed16[$], mfeed8[$], mfeed16[$];
    // Scoreboard queues.
    logic [31:0] exp_rx8[$], exp_rx16[$], exp_miso[$], obs_miso[$];
    logic [31:0] stim_words[$];
    int und8 = 0, und16 = 0, abt8 = 0, abt16 = 0;

    task automatic push_tx(input bit is16, input logic [31:0] w);
        if (is16) begin feed16.push_back(w & 32'hFFFF); mfeed16.push_back(w & 32'hFFFF); end
        else      begin feed8.push_back(w & 32'hFF);    mfeed8.push_back(w & 32'hFF);    end
    endtask

    initial begin
        if8.tx_valid = 1'b0;
        if8.tx_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && feed8.size() > 0) begin
                if8.tx_valid = 1'b1;
                if8.tx_data  = feed8[0][7:0];
                if (if8.tx_ready) void'(feed8.pop_front());
            end else begin
                if8.tx_valid = 1'b0;
            end
        end
    end

    initial begin
        if16.tx_valid = 1'b0;
        if16.tx_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && feed16.size() > 0) begin
                if16.tx_valid = 1'b1;
                if16.tx_data  = feed16[0][15:0];
                if (if16.tx_ready) void'(feed16.pop_front());
            end else begin
                if16.tx_valid = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        if (if8.tx_underrun)  und8++;
        if (if16.tx_underrun) und16++;
        if (if8.frame_abort)  abt8++;
        if (if16.frame_abort) abt16++;
        if (if8.rx_valid) begin
            if (exp_rx8.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx8_spurious: rx_valid with 0x%0h, none required", if8.rx_data);
            end else chk("rx8_data", {24'h0, if8.rx_data}, exp_rx8.pop_front());
        end
        if (if16.rx_valid) begin
            if (exp_rx16.size() == 0) begin
                checks++; failures++;
                $display("FAIL rx16_spurious: rx_valid with 0x%0h, none required", if16.rx_data);
            end else chk("rx16_data", {16'h0, if16.rx_data}, exp_rx16.pop_front());
        end
        while (obs_miso.size() > 0) begin
            if (exp_miso.size() == 0) begin
                checks++; failures++;
                $display("FAIL miso_extra: got 0x%0h with no word required", obs_miso.pop_front());
            end else chk("miso_word", obs_miso.pop_front(), exp_miso.pop_front());
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI frame of nbits bits (a trailing partial word aborts).
    task automatic run_frame(input bit is16, input bit pol, input bit pha, input int nbits);
        int w, nw, part, nloads, und_exp, und0, abt0, wc_exp;
        logic [31:0] mask, ldw, word, cap;
        logic bitv;
        w    = is16 ? 16 : 8;
        mask = is16 ? 32'hFFFF : 32'hFF;
        nw   = nbits / w;
        part = nbits % w;
        // Loads: cpha=0 loads on entry plus after every completed word;
        // cpha=1 loads at the start of every word that begins.
        nloads  = pha ? nw + ((part > 0) ? 1 : 0) : nw + 1;
        und_exp = 0;
        for (int i = 0; i < nloads; i++) begin
            if (is16 && mfeed16.size() > 0)      ldw = mfeed16.pop_front();
            else if (!is16 && mfeed8.size() > 0) ldw = mfeed8.pop_front();
            else begin
                ldw = is16 ? {16'h0, DEF16} : {24'h0, DEF8};
                und_exp++;
            end
            if (i < nw) exp_miso.push_back(ldw);
        end
        for (int i = 0; i < nw; i++) begin
            if (is16) exp_rx16.push_back(stim_words[i] & mask);
            else      exp_rx8.push_back(stim_words[i] & mask);
        end
        wc_exp = (is16 && nw > 3) ? 3 : nw;
        $display("frame: w=%0d mode=%0d%0d bits=%0d words=%0d loads=%0d", w, pol, pha, nbits, nw, nloads);

        use16 = is16; cpol_drv = pol; cpha_drv = pha; sck_drv = pol;
        wait_clk(8);
        und0 = is16 ? und16 : und8;
        abt0 = is16 ? abt16 : abt8;
        ssel_drv = 1'b0;
        wait_clk(2 * HALF);
        cap = '0;
        for (int k = 0; k < nbits; k++) begin
            word = stim_words[k / w];
            bitv = word[w - 1 - (k % w)];
            if (!pha) begin
                mosi_drv = bitv;
                wait_clk(HALF);
                cap = {cap[30:0], (is16 ? if16.miso : if8.miso)};
                sck_drv = ~pol;
                wait_clk(HALF);
                sck_drv = pol;
            end else begin
                sck_drv = ~pol;
                mosi_drv = bitv;
                wait_clk(HALF);
                cap = {cap[30:0], (is16 ? if16.miso : if8.miso)};
                sck_drv = pol;
                wait_clk(HALF);
            end
            if ((k % w) == (w - 1)) begin
                obs_miso.push_back(cap & mask);
                cap = '0;
            end
        end
        wait_clk(2 * HALF);
        chk("frame_active_in", {31'h0, (is16 ? if16.frame_active : if8.frame_active)}, 32'd1);
        chk("miso_oe_in",      {31'h0, (is16 ? if16.miso_oe : if8.miso_oe)}, 32'd1);
        chk("word_count", is16 ? {30'h0, if16.word_count} : {16'h0, if8.word_count}, 32'(wc_exp));
        ssel_drv = 1'b1;
        wait_clk(2 * HALF);
        chk("frame_active_out", {31'h0, (is16 ? if16.frame_active : if8.frame_active)}, 32'd0);
        chk("miso_idle", {30'h0, (is16 ? if16.miso_oe : if8.miso_oe), (is16 ? if16.miso : if8.miso)}, 32'd0);
        chk("underruns", 32'((is16 ? und16 : und8) - und0), 32'(und_exp));
        chk("aborts",    32'((is16 ? abt16 : abt8) - abt0), (part > 0) ? 32'd1 : 32'd0);
        chk("rx_missing", 32'(is16 ? exp_rx16.size() : exp_rx8.size()), 32'd0);
        chk("miso_missing", 32'(exp_miso.size()), 32'd0);
    endtask

    task automatic check_reset8(input string tag);
        chk({tag, "_miso"},         {31'h0, if8.miso}, 32'd0);
        chk({tag, "_miso_oe"},      {31'h0, if8.miso_oe}, 32'd0);
        chk({tag, "_rx_data"},      {24'h0, if8.rx_data}, 32'd0);
        chk({tag, "_rx_valid"},     {31'h0, if8.rx_valid}, 32'd0);
        chk({tag, "_tx_ready"},     {31'h0, if8.tx_ready}, 32'd1);
        chk({tag, "_tx_underrun"},  {31'h0, if8.tx_underrun}, 32'd0);
        chk({tag, "_frame_active"}, {31'h0, if8.frame_active}, 32'd0);
        chk({tag, "_frame_abort"},  {31'h0, if8.frame_abort}, 32'd0);
        chk({tag, "_word_count"},   {16'h0, if8.word_count}, 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int is16, nw, nbits, w, nfeed;
        logic [31:0] mask;
        // Reset and idle.
        rst_n = 1'b0;
        wait_clk(4);
        check_reset8("rst8");
        chk("rst16_tx_ready",   {31'h0, if16.tx_ready}, 32'd1);
        chk("rst16_word_count", {30'h0, if16.word_count}, 32'd0);
        rst_n = 1'b1;
        wait_clk(10);
        chk("idle8_frame_active", {31'h0, if8.frame_active}, 32'd0);

        // Single word 0xA5 out / 0x3C in, all four modes.
        for (int m = 0; m < 4; m++) begin
            push_tx(0, 32'hA5);
            stim_words = '{32'h3C};
            run_frame(0, m[1], m[0], 8);
        end

        // Back-to-back: three words, only two queued (third load underruns).
        push_tx(0, 32'h11);
        push_tx(0, 32'h22);
        stim_words = '{32'hDE, 32'hAD, 32'h7E};
        run_frame(0, 1'b0, 1'b1, 24);

        // Abort after 5 bits, then a clean frame.
        stim_words = '{32'h96};
        run_frame(0, 1'b0, 1'b0, 5);
        push_tx(0, 32'h5B);
        stim_words = '{32'h6B};
        run_frame(0, 1'b0, 1'b0, 8);

        // 16-bit instance: full word, 8-bit partial (must abort), saturation.
        push_tx(1, 32'h1234);
        stim_words = '{32'hBEEF};
        run_frame(1, 1'b0, 1'b0, 16);
        stim_words = '{32'hA55A};
        run_frame(1, 1'b0, 1'b0, 8);
        push_tx(1, 32'hCAFE);
        stim_words = '{32'h0001, 32'h8000, 32'hFFFF, 32'h7FFE};
        run_frame(1, 1'b1, 1'b1, 64);

        // Reset mid-frame; a select still low after release is not a frame.
        feed8.delete(); mfeed8.delete();
        use16 = 1'b0; cpol_drv = 1'b0; cpha_drv = 1'b0; sck_drv = 1'b0;
        wait_clk(8);
        ssel_drv = 1'b0;
        wait_clk(2 * HALF);
        for (int k = 0; k < 3; k++) begin
            sck_drv = 1'b1; wait_clk(HALF); sck_drv = 1'b0; wait_clk(HALF);
        end
        rst_n = 1'b0;
        wait_clk(2);
        check_reset8("midrst8");
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            mosi_drv = 1'($urandom_range(0, 1));
            sck_drv = 1'b1; wait_clk(HALF); sck_drv = 1'b0; wait_clk(HALF);
        end
        chk("stale_sel_frame_active", {31'h0, if8.frame_active}, 32'd0);
        chk("stale_sel_word_count",   {16'h0, if8.word_count}, 32'd0);
        ssel_drv = 1'b1;
        wait_clk(2 * HALF);

        // Randomised frames.
        for (int f = 0; f < 14; f++) begin
            is16 = int'($urandom_range(0, 1));
            w    = (is16 != 0) ? 16 : 8;
            mask = (is16 != 0) ? 32'hFFFF : 32'hFF;
            nw   = int'($urandom_range(0, 3));
            nbits = nw * w;
            if ($urandom_range(0, 3) == 0) nbits += int'($urandom_range(1, w - 1));
            if (nbits == 0) nbits = w;
            nfeed = int'($urandom_range(0, 3));
            for (int i = 0; i < nfeed; i++) push_tx(is16 != 0, $urandom & mask);
            stim_words.delete();
            for (int i = 0; i < 4; i++) stim_words.push_back($urandom & mask);
            run_frame(is16 != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nbits);
        end

        wait_clk(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
